// File: rtl/resize_mul_pkg.sv
// rtl/resize_mul_pkg.sv - shared limits and parameter checks for the resize multiplier
package resize_mul_pkg;

   localparam int MAX_STAGE = 8;
   localparam int MAX_OPW   = 32;
   localparam int MAX_OUTW  = 64;

   // Largest representable result, zero-extended to 64 bits.
   function automatic logic [63:0] sat_max(input int width, input bit is_signed);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < width - (is_signed ? 1 : 0)) r[i] = 1'b1;
      end
      return r;
   endfunction

   // Smallest representable result, sign-extended to 64 bits.
   function automatic logic [63:0] sat_min(input int width, input bit is_signed);
      logic [63:0] r;
      r = '0;
      if (is_signed) begin
         for (int i = 0; i < 64; i++) begin
            if (i >= width - 1) r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic bit params_ok(input int id, input int ns, input int w0, input int w1,
                                    input int wo, input int sh);
      return (id >= 0) &&
             (ns >= 1) && (ns <= MAX_STAGE) &&
             (w0 >= 2) && (w0 <= MAX_OPW) &&
             (w1 >= 2) && (w1 <= MAX_OPW) &&
             (wo >= 2) && (wo <= MAX_OUTW) &&
             (sh >= 0) && (sh < w0 + w1);
   endfunction

endpackage

// File: rtl/resize_mul_pipe_rs_if.sv
// rtl/resize_mul_pipe_rs_if.sv - sample-in / result-out bundle of the resize multiplier
interface resize_mul_pipe_rs_if #(
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 17,
   parameter int dout_WIDTH = 32
);
   logic                  din_vld;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  dout_vld;
   logic [dout_WIDTH-1:0] dout;
   logic                  dout_ovf;

   modport master (
      output din_vld, din0, din1,
      input  dout_vld, dout, dout_ovf
   );

   modport slave (
      input  din_vld, din0, din1,
      output dout_vld, dout, dout_ovf
   );
endinterface

// File: rtl/resize_mul_round_sat.sv
// rtl/resize_mul_round_sat.sv - round-half-up, shift and saturate/wrap of a P-bit product
module resize_mul_round_sat
   import resize_mul_pkg::*;
#(
   parameter int P          = 33,
   parameter int dout_WIDTH = 32,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SAT        = 1,
   parameter bit RES_SIGNED = 1'b0
) (
   input  logic [P-1:0]          prod_i,
   output logic [dout_WIDTH-1:0] dout_o,
   output logic                  ovf_o
);
   // Range checks are done in a width that holds any P+1 bit value and any 64-bit limit.
   localparam int W   = 66;
   localparam int K   = W - dout_WIDTH;
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [P:0] ONE = 1;
   localparam logic [P:0] RND = ((ROUND != 0) && (SHIFT > 0)) ? (ONE << RSH) : '0;

   localparam logic [63:0] MAX64 = sat_max(dout_WIDTH, RES_SIGNED);
   localparam logic [63:0] MIN64 = sat_min(dout_WIDTH, RES_SIGNED);
   localparam logic signed [W-1:0] MAXV = {2'b00, MAX64};
   localparam logic signed [W-1:0] MINV = {{2{MIN64[63]}}, MIN64};

   logic signed [P:0]   t_s;
   logic signed [P:0]   r_s;
   logic signed [W-1:0] r_w;
   logic signed [W-1:0] wrap_w;

   always_comb begin
      t_s    = $signed({RES_SIGNED & prod_i[P-1], prod_i}) + $signed(RND);
      r_s    = t_s >>> SHIFT;
      r_w    = {{(W-P-1){r_s[P]}}, r_s};
      wrap_w = RES_SIGNED ? ((r_w <<< K) >>> K) : ((r_w << K) >> K);
      dout_o = r_w[dout_WIDTH-1:0];
      ovf_o  = 1'b0;
      if (SAT != 0) begin
         if (r_w > MAXV) begin
            dout_o = MAXV[dout_WIDTH-1:0];
            ovf_o  = 1'b1;
         end else if (r_w < MINV) begin
            dout_o = MINV[dout_WIDTH-1:0];
            ovf_o  = 1'b1;
         end
      end else begin
         ovf_o = (wrap_w != r_w);
      end
   end

endmodule

// File: rtl/resize_mul_pipe_rs.sv
// rtl/resize_mul_pipe_rs.sv - pipelined signed/unsigned multiplier with round, shift and saturate
module resize_mul_pipe_rs
   import resize_mul_pkg::*;
#(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 16,
   parameter int din1_WIDTH  = 17,
   parameter int dout_WIDTH  = 32,
   parameter int din0_SIGNED = 0,
   parameter int din1_SIGNED = 0,
   parameter int SHIFT       = 0,
   parameter int ROUND       = 0,
   parameter int SAT         = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce,
   resize_mul_pipe_rs_if.slave bus
);
   localparam int P          = din0_WIDTH + din1_WIDTH;
   localparam bit A_SX       = (din0_SIGNED != 0);
   localparam bit B_SX       = (din1_SIGNED != 0);
   localparam bit RES_SIGNED = A_SX | B_SX;

   if (!params_ok(ID, NUM_STAGE, din0_WIDTH, din1_WIDTH, dout_WIDTH, SHIFT)) begin : g_bad_param
      $error("resize_mul_pipe_rs: parameter out of range");
   end

   logic [din0_WIDTH-1:0] a_s;
   logic [din1_WIDTH-1:0] b_s;
   logic                  vld_s;
   logic [P-1:0]          a_ext;
   logic [P-1:0]          b_ext;
   logic [P-1:0]          prod_c;
   logic [P-1:0]          prod_f;
   logic                  vld_f;

   // With a single stage the output register is the only register in the path.
   if (NUM_STAGE == 1) begin : g_in_comb
      assign a_s   = bus.din0;
      assign b_s   = bus.din1;
      assign vld_s = bus.din_vld;
   end else begin : g_in_reg
      logic [din0_WIDTH-1:0] a_q;
      logic [din1_WIDTH-1:0] b_q;
      logic                  v_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
         end else if (ce) begin
            a_q <= bus.din0;
            b_q <= bus.din1;
            v_q <= bus.din_vld;
         end
      end

      assign a_s   = a_q;
      assign b_s   = b_q;
      assign vld_s = v_q;
   end

   assign a_ext  = {{din1_WIDTH{A_SX & a_s[din0_WIDTH-1]}}, a_s};
   assign b_ext  = {{din0_WIDTH{B_SX & b_s[din1_WIDTH-1]}}, b_s};
   assign prod_c = a_ext * b_ext;

   if (NUM_STAGE <= 2) begin : g_no_chain
      assign prod_f = prod_c;
      assign vld_f  = vld_s;
   end else begin : g_chain
      logic [P-1:0]           pipe_q [NUM_STAGE-2];
      logic [NUM_STAGE-3:0]   pv_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < NUM_STAGE - 2; i++) pipe_q[i] <= '0;
            pv_q <= '0;
         end else if (ce) begin
            pipe_q[0] <= prod_c;
            pv_q[0]   <= vld_s;
            for (int i = 1; i < NUM_STAGE - 2; i++) begin
               pipe_q[i] <= pipe_q[i-1];
               pv_q[i]   <= pv_q[i-1];
            end
         end
      end

      assign prod_f = pipe_q[NUM_STAGE-3];
      assign vld_f  = pv_q[NUM_STAGE-3];
   end

   logic [dout_WIDTH-1:0] rs_dout;
   logic                  rs_ovf;

   resize_mul_round_sat #(
      .P          (P),
      .dout_WIDTH (dout_WIDTH),
      .SHIFT      (SHIFT),
      .ROUND      (ROUND),
      .SAT        (SAT),
      .RES_SIGNED (RES_SIGNED)
   ) u_round_sat (
      .prod_i (prod_f),
      .dout_o (rs_dout),
      .ovf_o  (rs_ovf)
   );

   logic [dout_WIDTH-1:0] dout_d, dout_q;
   logic                  ovf_d, ovf_q;
   logic                  vld_d, vld_q;

   // Data loads freely; only the overflow flag is qualified so it never shows on an empty slot.
   always_comb begin
      dout_d = rs_dout;
      ovf_d  = rs_ovf & vld_f;
      vld_d  = vld_f;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else if (ce) begin
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         vld_q  <= vld_d;
      end
   end

   assign bus.dout     = dout_q;
   assign bus.dout_ovf = ovf_q;
   assign bus.dout_vld = vld_q;

endmodule

// File: tb/tb_resize_mul_pipe_rs.sv
// tb/tb_resize_mul_pipe_rs.sv - directed bench for resize_mul_pipe_rs across stage counts and modes
`timescale 1ns/1ps
module tb_resize_mul_pipe_rs;

   typedef struct {
      int          cyc;
      logic        ovf;
      logic [31:0] d;
   } rec_t;

   localparam int ND = 6;

   logic        clk = 1'b0;
   logic        reset, ce, vld_u, vld_s;
   logic [15:0] a16, ra;
   logic [16:0] b17, rb;
   logic [7:0]  a8, b8;
   logic [63:0] p;
   int          en_cyc = 0;
   logic        ce_seen = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          ovf_bad = 0;
   int          lat [ND];
   rec_t        act_q [ND][$];
   rec_t        exp_q [ND][$];

   always #5 clk = ~clk;

   resize_mul_pipe_rs_if #(16, 17, 32) if_n1 ();
   resize_mul_pipe_rs_if #(16, 17, 32) if_n2 ();
   resize_mul_pipe_rs_if #(16, 17, 32) if_n3 ();
   resize_mul_pipe_rs_if #(16, 17, 32) if_n8 ();
   resize_mul_pipe_rs_if #(8, 8, 8)    if_s8 ();
   resize_mul_pipe_rs_if #(8, 8, 8)    if_w8 ();

   assign if_n1.din_vld = vld_u; assign if_n1.din0 = a16; assign if_n1.din1 = b17;
   assign if_n2.din_vld = vld_u; assign if_n2.din0 = a16; assign if_n2.din1 = b17;
   assign if_n3.din_vld = vld_u; assign if_n3.din0 = a16; assign if_n3.din1 = b17;
   assign if_n8.din_vld = vld_u; assign if_n8.din0 = a16; assign if_n8.din1 = b17;
   assign if_s8.din_vld = vld_s; assign if_s8.din0 = a8;  assign if_s8.din1 = b8;
   assign if_w8.din_vld = vld_s; assign if_w8.din0 = a8;  assign if_w8.din1 = b8;

   resize_mul_pipe_rs #(.ID(0), .NUM_STAGE(1)) u_n1 (.clk(clk), .reset(reset), .ce(ce), .bus(if_n1.slave));
   resize_mul_pipe_rs #(.ID(1), .NUM_STAGE(2)) u_n2 (.clk(clk), .reset(reset), .ce(ce), .bus(if_n2.slave));
   resize_mul_pipe_rs #(.ID(2), .NUM_STAGE(3)) u_n3 (.clk(clk), .reset(reset), .ce(ce), .bus(if_n3.slave));
   resize_mul_pipe_rs #(.ID(3), .NUM_STAGE(8)) u_n8 (.clk(clk), .reset(reset), .ce(ce), .bus(if_n8.slave));
   resize_mul_pipe_rs #(.ID(4), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
                        .din0_SIGNED(1), .din1_SIGNED(1), .SHIFT(4), .ROUND(1), .SAT(1))
      u_s8 (.clk(clk), .reset(reset), .ce(ce), .bus(if_s8.slave));
   resize_mul_pipe_rs #(.ID(5), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
                        .din0_SIGNED(1), .din1_SIGNED(1), .SHIFT(4), .ROUND(1), .SAT(0))
      u_w8 (.clk(clk), .reset(reset), .ce(ce), .bus(if_w8.slave));

   always @(posedge clk) begin
      ce_seen <= ce && !reset;
      if (ce && !reset) en_cyc <= en_cyc + 1;
   end

   always @(negedge clk) begin
      if (ce_seen) begin
         if (if_n1.dout_vld) act_q[0].push_back('{en_cyc, if_n1.dout_ovf, if_n1.dout});
         if (if_n2.dout_vld) act_q[1].push_back('{en_cyc, if_n2.dout_ovf, if_n2.dout});
         if (if_n3.dout_vld) act_q[2].push_back('{en_cyc, if_n3.dout_ovf, if_n3.dout});
         if (if_n8.dout_vld) act_q[3].push_back('{en_cyc, if_n8.dout_ovf, if_n8.dout});
         if (if_s8.dout_vld) act_q[4].push_back('{en_cyc, if_s8.dout_ovf, {24'h0, if_s8.dout}});
         if (if_w8.dout_vld) act_q[5].push_back('{en_cyc, if_w8.dout_ovf, {24'h0, if_w8.dout}});
      end
      if ((!if_n1.dout_vld && if_n1.dout_ovf) || (!if_n2.dout_vld && if_n2.dout_ovf) ||
          (!if_n3.dout_vld && if_n3.dout_ovf) || (!if_n8.dout_vld && if_n8.dout_ovf) ||
          (!if_s8.dout_vld && if_s8.dout_ovf) || (!if_w8.dout_vld && if_w8.dout_ovf))
         ovf_bad <= ovf_bad + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_u(input logic [15:0] a, input logic [16:0] b,
                          input logic [31:0] ed, input logic eo);
      a16 = a; b17 = b; vld_u = 1'b1; vld_s = 1'b0;
      for (int i = 0; i < 4; i++) exp_q[i].push_back('{en_cyc + lat[i], eo, ed});
      @(posedge clk); #1;
   endtask

   task automatic drive_s(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] e_sat, input logic o_sat,
                          input logic [7:0] e_wrap, input logic o_wrap);
      a8 = a; b8 = b; vld_s = 1'b1; vld_u = 1'b0;
      exp_q[4].push_back('{en_cyc + lat[4], o_sat, {24'h0, e_sat}});
      exp_q[5].push_back('{en_cyc + lat[5], o_wrap, {24'h0, e_wrap}});
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      vld_u = 1'b0; vld_s = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < ND; i++) begin
         check($sformatf("%s_count%0d", tag, i), act_q[i].size(), exp_q[i].size());
         for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
            check($sformatf("%s_dout%0d_%0d", tag, i, j), act_q[i][j].d, exp_q[i][j].d);
            check($sformatf("%s_ovf%0d_%0d", tag, i, j), act_q[i][j].ovf, exp_q[i][j].ovf);
            check($sformatf("%s_cyc%0d_%0d", tag, i, j), act_q[i][j].cyc, exp_q[i][j].cyc);
         end
         act_q[i].delete();
         exp_q[i].delete();
      end
   endtask

   task automatic stall();
      logic [31:0] d3, d8;
      logic        v3, v8, o3, o8;
      ce = 1'b0;
      d3 = if_n3.dout; v3 = if_n3.dout_vld; o3 = if_n3.dout_ovf;
      d8 = if_n8.dout; v8 = if_n8.dout_vld; o8 = if_n8.dout_ovf;
      check("stall_n3_busy", v3, 1'b1);
      repeat (5) begin
         @(posedge clk); #2;
         check("stall_n3_dout", if_n3.dout, d3);
         check("stall_n3_vld", if_n3.dout_vld, v3);
         check("stall_n3_ovf", if_n3.dout_ovf, o3);
         check("stall_n8_dout", if_n8.dout, d8);
         check("stall_n8_vld", if_n8.dout_vld, v8);
         check("stall_n8_ovf", if_n8.dout_ovf, o8);
      end
      ce = 1'b1;
   endtask

   initial begin
      lat[0] = 1; lat[1] = 2; lat[2] = 3; lat[3] = 8; lat[4] = 3; lat[5] = 3;
      reset = 1'b1; ce = 1'b0; vld_u = 1'b0; vld_s = 1'b0;
      a16 = '0; b17 = '0; a8 = '0; b8 = '0;

      @(posedge clk); #1;
      check("rst_n3_vld", if_n3.dout_vld, 1'b0);
      check("rst_n3_dout", if_n3.dout, 32'h0);
      check("rst_n3_ovf", if_n3.dout_ovf, 1'b0);
      check("rst_s8_dout", if_s8.dout, 8'h0);
      @(posedge clk); #1;
      reset = 1'b0; ce = 1'b1;

      drive_u(16'hFFFF, 17'h1FFFF, 32'hFFFFFFFF, 1'b1);
      drive_u(16'd1234, 17'd5678,  32'd7006652,  1'b0);
      drive_u(16'hFFFF, 17'h10001, 32'hFFFFFFFF, 1'b0);
      drive_u(16'hFFFF, 17'h10002, 32'hFFFFFFFF, 1'b1);
      drive_u(16'h0000, 17'h1FFFF, 32'h00000000, 1'b0);
      idle(1);
      drive_u(16'd1, 17'd1, 32'd1, 1'b0);
      idle(12);
      compare_all("dir");

      for (int i = 0; i < 100; i++) begin
         if (i == 50) stall();
         ra = 16'($urandom);
         rb = 17'($urandom);
         p  = 64'(ra) * 64'(rb);
         drive_u(ra, rb, (p > 64'hFFFFFFFF) ? 32'hFFFFFFFF : p[31:0], p > 64'hFFFFFFFF);
      end
      idle(12);
      compare_all("burst");

      drive_s(8'h07, 8'h03, 8'h01, 1'b0, 8'h01, 1'b0);
      drive_s(8'hF9, 8'h03, 8'hFF, 1'b0, 8'hFF, 1'b0);
      drive_s(8'h80, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1);
      drive_s(8'h80, 8'h7F, 8'h80, 1'b1, 8'h08, 1'b1);
      drive_s(8'h7F, 8'h7F, 8'h7F, 1'b1, 8'hF0, 1'b1);
      drive_s(8'h08, 8'h01, 8'h01, 1'b0, 8'h01, 1'b0);
      drive_s(8'h07, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
      drive_s(8'hF8, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
      drive_s(8'hF7, 8'h01, 8'hFF, 1'b0, 8'hFF, 1'b0);
      drive_s(8'h7F, 8'h10, 8'h7F, 1'b0, 8'h7F, 1'b0);
      drive_s(8'h7F, 8'h11, 8'h7F, 1'b1, 8'h87, 1'b1);
      drive_s(8'h80, 8'h10, 8'h80, 1'b0, 8'h80, 1'b0);
      drive_s(8'h80, 8'h11, 8'h80, 1'b1, 8'h78, 1'b1);
      idle(8);
      compare_all("signed");

      a16 = 16'd3; b17 = 17'd5; a8 = 8'h05; b8 = 8'h03; vld_u = 1'b1; vld_s = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_n1_vld", if_n1.dout_vld, 1'b0);
      check("arst_n1_dout", if_n1.dout, 32'h0);
      check("arst_n2_vld", if_n2.dout_vld, 1'b0);
      check("arst_n2_dout", if_n2.dout, 32'h0);
      check("arst_n3_vld", if_n3.dout_vld, 1'b0);
      check("arst_n3_dout", if_n3.dout, 32'h0);
      check("arst_n8_vld", if_n8.dout_vld, 1'b0);
      check("arst_n8_ovf", if_n8.dout_ovf, 1'b0);
      check("arst_s8_vld", if_s8.dout_vld, 1'b0);
      check("arst_s8_dout", if_s8.dout, 8'h0);
      vld_u = 1'b0; vld_s = 1'b0;
      for (int i = 0; i < ND; i++) begin
         act_q[i].delete();
         exp_q[i].delete();
      end
      @(posedge clk); #3;
      reset = 1'b0;
      idle(12);
      compare_all("post_rst");

      drive_u(16'd100, 17'd200, 32'd20000, 1'b0);
      drive_s(8'h20, 8'h02, 8'h04, 1'b0, 8'h04, 1'b0);
      idle(12);
      compare_all("after_rst");

      check("ovf_without_vld", ovf_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
